// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - shared state encoding and score constants for the baccarat control block
//
// Contents:
//   state_t     : FSM states in deal order, 4-bit encoding
//   NATURAL_LO  : lowest natural score (8)
//   NATURAL_HI  : highest natural score (9)
//   STAND_MAX   : highest score that still draws a third card (5)
//   CARD_MAX    : highest rank that counts at face value (9)
//   is_natural  : true when a two-card score is a natural
package baccarat_pkg;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_P1     = 4'd1,
        ST_D1     = 4'd2,
        ST_P2     = 4'd3,
        ST_D2     = 4'd4,
        ST_EVAL2  = 4'd5,
        ST_P3     = 4'd6,
        ST_EVAL3  = 4'd7,
        ST_D3     = 4'd8,
        ST_RESULT = 4'd9,
        ST_PWIN   = 4'd10,
        ST_DWIN   = 4'd11,
        ST_TIE    = 4'd12
    } state_t;

    localparam logic [3:0] NATURAL_LO = 4'd8;
    localparam logic [3:0] NATURAL_HI = 4'd9;
    localparam logic [3:0] STAND_MAX  = 4'd5;
    localparam logic [3:0] CARD_MAX   = 4'd9;

    // Out-of-range scores (10..15) are deliberately not naturals.
    function automatic logic is_natural(input logic [3:0] score);
        return (score == NATURAL_LO) || (score == NATURAL_HI);
    endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// rtl/banker_draw_rule.sv - banker third-card decision after the player has drawn
//
// Ports:
//   dscore : in  4  banker two-card score
//   pcard3 : in  4  rank of the player's third card (10..15 count as 0)
//   draw   : out 1  banker takes a third card
module banker_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] card_value;

    always_comb begin
        // Face cards and tens are worth nothing.
        card_value = (pcard3 <= CARD_MAX) ? pcard3 : 4'd0;
        draw       = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (card_value != 4'd8);
            4'd4:             draw = (card_value >= 4'd2) && (card_value <= 4'd7);
            4'd5:             draw = (card_value >= 4'd4) && (card_value <= 4'd7);
            4'd6:             draw = (card_value >= 4'd6) && (card_value <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/state_machine.sv
// rtl/state_machine.sv - baccarat deal/draw/result control FSM
//
// Ports:
//   slow_clock       : in  1  sole clock, state advances on rising edge
//   resetb           : in  1  synchronous active-high reset to RST
//   pscore           : in  4  player score from the datapath
//   dscore           : in  4  dealer score from the datapath
//   pcard3           : in  4  player third-card rank
//   load_pcard1..3   : out 1  player card register load enables
//   load_dcard1..3   : out 1  dealer card register load enables
//   player_win_light : out 1  lit in PWIN and TIE
//   dealer_win_light : out 1  lit in DWIN and TIE
module state_machine
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    state_t state;
    state_t next_state;
    logic   banker_draws;

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draws)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_RST:   next_state = ST_P1;
            ST_P1:    next_state = ST_D1;
            ST_D1:    next_state = ST_P2;
            ST_P2:    next_state = ST_D2;
            ST_D2:    next_state = ST_EVAL2;
            ST_EVAL2: begin
                if (is_natural(pscore) || is_natural(dscore)) begin
                    next_state = ST_RESULT;
                end else if (pscore <= STAND_MAX) begin
                    next_state = ST_P3;
                end else if (dscore <= STAND_MAX) begin
                    // Player stood on 6/7, banker plays the simple rule.
                    next_state = ST_D3;
                end else begin
                    next_state = ST_RESULT;
                end
            end
            ST_P3:    next_state = ST_EVAL3;
            ST_EVAL3: next_state = banker_draws ? ST_D3 : ST_RESULT;
            ST_D3:    next_state = ST_RESULT;
            ST_RESULT: begin
                if (pscore > dscore) begin
                    next_state = ST_PWIN;
                end else if (dscore > pscore) begin
                    next_state = ST_DWIN;
                end else begin
                    next_state = ST_TIE;
                end
            end
            ST_PWIN:  next_state = ST_PWIN;
            ST_DWIN:  next_state = ST_DWIN;
            ST_TIE:   next_state = ST_TIE;
            default:  next_state = ST_RST;
        endcase
    end

    // Outputs are registered from next_state, so each one is a pure decode
    // of the state register while staying glitch-free toward the datapath.
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            state            <= ST_RST;
            load_pcard1      <= 1'b0;
            load_pcard2      <= 1'b0;
            load_pcard3      <= 1'b0;
            load_dcard1      <= 1'b0;
            load_dcard2      <= 1'b0;
            load_dcard3      <= 1'b0;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else begin
            state            <= next_state;
            load_pcard1      <= (next_state == ST_P1);
            load_pcard2      <= (next_state == ST_P2);
            load_pcard3      <= (next_state == ST_P3);
            load_dcard1      <= (next_state == ST_D1);
            load_dcard2      <= (next_state == ST_D2);
            load_dcard3      <= (next_state == ST_D3);
            player_win_light <= (next_state == ST_PWIN) || (next_state == ST_TIE);
            dealer_win_light <= (next_state == ST_DWIN) || (next_state == ST_TIE);
        end
    end

endmodule

// File: tb/tb_state_machine.sv
// tb/tb_state_machine.sv - directed and random game checks for state_machine
module tb_state_machine;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b1;
    logic [3:0] pscore     = 4'd0;
    logic [3:0] dscore     = 4'd0;
    logic [3:0] pcard3     = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;

    state_machine dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    always #5 slow_clock = ~slow_clock;

    // Output vector: {p1, d1, p2, d2, p3, d3, player light, dealer light}
    localparam logic [7:0] V_NONE = 8'h00;
    localparam logic [7:0] V_LP1  = 8'h80;
    localparam logic [7:0] V_LD1  = 8'h40;
    localparam logic [7:0] V_LP2  = 8'h20;
    localparam logic [7:0] V_LD2  = 8'h10;
    localparam logic [7:0] V_LP3  = 8'h08;
    localparam logic [7:0] V_LD3  = 8'h04;
    localparam logic [7:0] V_PW   = 8'h02;
    localparam logic [7:0] V_DW   = 8'h01;

    logic [7:0] obs;
    assign obs = {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                  load_pcard3, load_dcard3, player_win_light, dealer_win_light};

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    // Banker table as drawn on the card: thresholds 2/4/6 for scores 4/5/6.
    function automatic bit banker_wants(input int d, input int card);
        int v;
        int lowest;
        v = (card > 9) ? 0 : card;
        if (d <= 2) return 1'b1;
        if (d == 3) return v != 8;
        if (d >= 7) return 1'b0;
        lowest = 2 * (d - 3);
        return (v >= lowest) && (v <= 7);
    endfunction

    // Expected per-edge outputs of one game, starting at the reset edge.
    task automatic build_model(input int p2, input int d2, input int pc3,
                               input int p3, input int d3);
        bit natural, pdraw, bdraw;
        int pf, df;
        exp_q.delete();
        exp_q.push_back(V_NONE);
        exp_q.push_back(V_LP1);
        exp_q.push_back(V_LD1);
        exp_q.push_back(V_LP2);
        exp_q.push_back(V_LD2);
        exp_q.push_back(V_NONE);
        natural = (p2 == 8) || (p2 == 9) || (d2 == 8) || (d2 == 9);
        pdraw   = !natural && (p2 <= 5);
        if (natural)    bdraw = 1'b0;
        else if (pdraw) bdraw = banker_wants(d2, pc3);
        else            bdraw = (d2 <= 5);
        if (pdraw) begin
            exp_q.push_back(V_LP3);
            exp_q.push_back(V_NONE);
        end
        if (bdraw) exp_q.push_back(V_LD3);
        exp_q.push_back(V_NONE);
        pf = pdraw ? p3 : p2;
        df = bdraw ? d3 : d2;
        repeat (3) begin
            if (pf > df)      exp_q.push_back(V_PW);
            else if (df > pf) exp_q.push_back(V_DW);
            else              exp_q.push_back(V_PW | V_DW);
        end
    endtask

    task automatic check(input string tag, input logic [7:0] expected);
        vectors++;
        assert (obs === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expected);
        end
    endtask

    // Scores stay garbage until the datapath would have produced them, so
    // any early sampling shows up as a wrong path.
    task automatic run_game(input int p2, input int d2, input int pc3,
                            input int p3, input int d3,
                            input int abort_at, input bit glitch);
        build_model(p2, d2, pc3, p3, d3);
        @(negedge slow_clock);
        resetb = 1'b1;
        pscore = 4'($urandom_range(0, 15));
        dscore = 4'($urandom_range(0, 15));
        pcard3 = 4'($urandom_range(0, 15));
        @(posedge slow_clock);
        @(negedge slow_clock);
        resetb = 1'b0;
        check("reset", exp_q[0]);
        for (int i = 1; i < exp_q.size(); i++) begin
            @(posedge slow_clock);
            @(negedge slow_clock);
            check($sformatf("p%0d_d%0d_c%0d step%0d", p2, d2, pc3, i), exp_q[i]);
            if (i == abort_at) return;
            if (exp_q[i] == V_LD2) begin
                pscore = 4'(p2);
                dscore = 4'(d2);
                pcard3 = 4'(pc3);
            end
            if (exp_q[i] == V_LP3) pscore = 4'(p3);
            if (exp_q[i] == V_LD3) dscore = 4'(d3);
            if (glitch && i == 2) begin
                // Pulse between edges must be ignored.
                resetb = 1'b1;
                #1 resetb = 1'b0;
            end
        end
    endtask

    initial begin
        int p2, d2, pc3, p3, d3;

        run_game(0, 0, 0, 0, 0, -1, 1'b0);      // full draw, tie
        run_game(7, 8, 0, 0, 0, -1, 1'b0);      // banker natural
        run_game(7, 6, 0, 0, 0, -1, 1'b0);      // both stand
        run_game(3, 3, 8, 1, 4, -1, 1'b0);      // banker 3 stands on an 8
        run_game(3, 3, 2, 5, 4, -1, 1'b0);      // both draw
        run_game(4, 5, 5, 9, 6, -1, 1'b1);      // banker 5 draws on a 5, glitch ignored
        run_game(6, 4, 0, 0, 7, -1, 1'b0);      // banker only draws
        run_game(9, 9, 0, 0, 0, -1, 1'b0);      // double natural tie
        run_game(12, 3, 0, 0, 2, -1, 1'b0);     // out-of-range player score
        run_game(2, 6, 12, 7, 1, -1, 1'b0);     // face card counts as zero
        run_game(4, 5, 5, 9, 6, 3, 1'b0);       // aborted mid-deal
        run_game(4, 5, 5, 9, 6, -1, 1'b0);      // fresh deal after abort

        for (int g = 0; g < 200; g++) begin
            if ($urandom_range(0, 7) == 0) begin
                p2 = $urandom_range(0, 15);
                d2 = $urandom_range(0, 15);
            end else begin
                p2 = $urandom_range(0, 9);
                d2 = $urandom_range(0, 9);
            end
            pc3 = $urandom_range(0, 15);
            p3  = $urandom_range(0, 9);
            d3  = $urandom_range(0, 9);
            run_game(p2, d2, pc3, p3, d3,
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 8)) : -1,
                     1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
